// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, word width and transaction bit-count helper for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} spi_state_t;
  localparam int MAX_BITS = 32;
  function automatic logic [5:0] nbits(input logic [1:0] n);
    return {1'b0, n, 3'b000} + 6'd8;
  endfunction
endpackage

// File: rtl/module_spi_tick.sv
// module_spi_tick: phase timer (clk_i, rst_n_i, clr_i holds it at zero, tick_o pulses on the DIV-th cycle of a phase)
module module_spi_tick #(
  parameter int DIV = 5
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);
  logic [7:0] cnt;
  assign tick_o = cnt == 8'(DIV - 1);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else cnt <= (clr_i || tick_o) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/module_spi_master.sv
// module_spi_master: mode-0 SPI master, 1-4 bytes per start_i/n_bytes_i/tx_data_i; sclk_o/mosi_o/cs_n_o/miso_i bus; busy_o, wr_en_o strobe with rx_data_o
module module_spi_master
  import spi_pkg::*;
#(
  parameter int DIV       = 5,
  parameter int MAX_BYTES = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [1:0]          n_bytes_i,
  input  logic [MAX_BITS-1:0] tx_data_i,
  input  logic                miso_i,
  output logic                sclk_o,
  output logic                mosi_o,
  output logic                cs_n_o,
  output logic                busy_o,
  output logic                wr_en_o,
  output logic [MAX_BITS-1:0] rx_data_o
);
  localparam int W = 8 * MAX_BYTES;
  spi_state_t state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic [W-1:0] tx_q, tx_d, rx_sr_q, rx_sr_d;
  logic [MAX_BITS-1:0] rx_data_d;
  logic sclk_d, mosi_d, cs_n_d, tick;
  module_spi_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );
  assign busy_o  = state_q != IDLE;
  assign wr_en_o = state_q == DONE;
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_o;
    sclk_d    = sclk_o;
    mosi_d    = mosi_o;
    cs_n_d    = cs_n_o;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SETUP;
        tx_d    = tx_data_i;
        bit_d   = 5'(nbits(n_bytes_i) - 6'd1);
        mosi_d  = tx_data_i[bit_d];
        cs_n_d  = 1'b0;
        rx_sr_d = '0;
      end
      SETUP: if (tick) state_d = LOW;
      LOW: if (tick) begin
        state_d = HIGH;
        sclk_d  = 1'b1;
        rx_sr_d = {rx_sr_q[W-2:0], miso_i};
      end
      HIGH: if (tick) begin
        sclk_d  = 1'b0;
        state_d = (bit_q == 5'd0) ? HOLD : LOW;
        bit_d   = (bit_q == 5'd0) ? bit_q : bit_q - 5'd1;
        mosi_d  = (bit_q == 5'd0) ? mosi_o : tx_q[bit_q - 5'd1];
      end
      HOLD: if (tick) begin
        state_d   = DONE;
        cs_n_d    = 1'b1;
        rx_data_d = rx_sr_q;
      end
      DONE: begin
        state_d = IDLE;
        mosi_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      rx_data_o <= '0;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
      cs_n_o    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_o <= rx_data_d;
      sclk_o    <= sclk_d;
      mosi_o    <= mosi_d;
      cs_n_o    <= cs_n_d;
    end
endmodule

// File: tb/tb_module_spi_master.sv
// tb_module_spi_master: directed scoreboard bench for module_spi_master with loopback and fixed-word slave models
module tb_module_spi_master;
  localparam int DIV = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] n_bytes = 2'd0;
  logic [31:0] tx_data = 32'd0;
  logic miso, sclk_o, mosi_o, cs_n_o, busy_o, wr_en_o;
  logic [31:0] rx_data_o;
  int compared = 0;
  int mismatched = 0;
  int rises = 0;
  int wr_cnt = 0;
  int idx = 0;
  logic [31:0] mosi_log = 32'd0;
  logic [31:0] slave_word = 32'd0;
  logic [31:0] reg_q;
  logic loopback = 1'b1;
  logic [31:0] exp_q[$];

  module_spi_master #(.DIV(DIV), .MAX_BYTES(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .n_bytes_i(n_bytes),
    .tx_data_i(tx_data),
    .miso_i   (miso),
    .sclk_o   (sclk_o),
    .mosi_o   (mosi_o),
    .cs_n_o   (cs_n_o),
    .busy_o   (busy_o),
    .wr_en_o  (wr_en_o),
    .rx_data_o(rx_data_o)
  );

  always #5 clk = ~clk;

  assign miso = loopback ? mosi_o : slave_word[5'(31 - idx)];
  always @(posedge sclk_o) begin
    rises <= rises + 1;
    mosi_log <= {mosi_log[30:0], mosi_o};
  end
  always @(negedge sclk_o or posedge cs_n_o) idx <= cs_n_o ? 0 : idx + 1;
  always @(negedge clk) if (wr_en_o) wr_cnt <= wr_cnt + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) reg_q <= 32'd0;
    else if (wr_en_o) reg_q <= rx_data_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] n, input logic [31:0] tx, input logic [31:0] exp_rx,
                         input logic lb, input logic poke);
    int lat, r0, w0, nb;
    logic [31:0] mask, got;
    nb = 8 * (int'(n) + 1);
    mask = (nb == 32) ? 32'hFFFF_FFFF : (32'h1 << nb) - 32'h1;
    loopback = lb;
    slave_word = exp_rx;
    @(negedge clk);
    start = 1'b1;
    n_bytes = n;
    tx_data = tx;
    exp_q.push_back(exp_rx);
    r0 = rises;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b0;
    n_bytes = ~n;
    tx_data = ~tx;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("cs_after_start", 32'(cs_n_o), 32'd0);
    lat = 1;
    while (!wr_en_o && lat < 5000) begin
      start = (poke && lat == 20) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, 1 + DIV + 2 * DIV * nb + DIV);
    got = exp_q.pop_front();
    chk("rx_data", rx_data_o, got);
    chk("sclk_rises", rises - r0, nb);
    chk("mosi_bits", mosi_log & mask, tx & mask);
    chk("busy_in_done", 32'(busy_o), 32'd1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wr_pulses", wr_cnt - w0, 32'd1);
    chk("cs_after_done", 32'(cs_n_o), 32'd1);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    chk("wr_en_low", 32'(wr_en_o), 32'd0);
    chk("reg_out", reg_q, got);
    if (poke) begin
      repeat (20) @(negedge clk);
      chk("no_restart_cs", 32'(cs_n_o), 32'd1);
      chk("no_restart_busy", 32'(busy_o), 32'd0);
      chk("no_extra_wr", wr_cnt - w0, 32'd1);
    end
  endtask

  initial begin
    int lat, r0, w0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_cs", 32'(cs_n_o), 32'd1);
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_rx", rx_data_o, 32'd0);
    run_txn(2'd0, 32'h0000_00A5, 32'h0000_00A5, 1'b1, 1'b0);
    run_txn(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    run_txn(2'd0, 32'h0000_003C, 32'h0000_003C, 1'b1, 1'b1);
    loopback = 1'b1;
    @(negedge clk);
    start = 1'b1;
    n_bytes = 2'd1;
    tx_data = 32'h0000_C3A5;
    r0 = rises;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (rises - r0 < 5 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_reach_bit5", rises - r0, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs_n_o), 32'd1);
    chk("midrst_sclk", 32'(sclk_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_wr_en", 32'(wr_en_o), 32'd0);
    chk("midrst_rx", rx_data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_no_wr", wr_cnt - w0, 32'd0);
    chk("midrst_rx_held", rx_data_o, 32'd0);
    run_txn(2'd1, 32'h0000_BEEF, 32'h0000_BEEF, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
